top_sched: RTL and testbench

Round-robin issue scheduler that shares one `module_top` arithmetic datapath (three 12-bit operands in, 14-bit result out, `e` as issue strobe) between NREQ requesters. It sits directly in front of the datapath and drives its operand and enable inputs. It tracks in-flight operations with a fixed-latency tag pipeline and returns each result to its requester in issue order through a credit-protected response FIFO.

---
 rtl/top_sched_pkg.sv | 22 ++
 rtl/top_sched_rsp_fifo.sv | 62 ++++++
 rtl/top_sched.sv | 137 +++++++++++++
 tb/tb_top_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_sched_pkg.sv
// top_sched_pkg: shared constants, tag type and helpers for the top_sched issue scheduler.
package top_sched_pkg;

  localparam int W_DEF   = 12;
  localparam int YW_DEF  = 14;
  localparam int ID_MAXW = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin pointer starts on the last requester so requester 0 wins first.
  function automatic int ptr_reset(input int n);
    return n - 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
  } tag_t;

endpackage

// File: rtl/top_sched_rsp_fifo.sv
// top_sched_rsp_fifo: response FIFO with a registered head stage; an empty FIFO
// forwards a push straight into the head so the response appears one cycle later.
module top_sched_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          out_valid,
  output logic [DW-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          load, from_mem, bypass, wr_en;

  assign load     = !out_valid || pop;
  assign from_mem = load && (cnt != '0);
  assign bypass   = load && (cnt == '0) && push;
  assign wr_en    = push && !bypass;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (from_mem) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, from_mem})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (load) begin
        if (from_mem) begin
          dout      <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          dout      <= din;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/top_sched.sv
// top_sched: round-robin issue scheduler sharing one fixed-latency datapath between requesters.
// Define TOP_SCHED_STATS_EN to add per-requester saturating accept counters (issue_cnt).
module top_sched
  import top_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int W         = W_DEF,
  parameter int YW        = YW_DEF,
  parameter int DP_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  input  logic [NREQ*W-1:0]       req_c,
  output logic                    dp_e,
  output logic [W-1:0]            dp_a,
  output logic [W-1:0]            dp_b,
  output logic [W-1:0]            dp_c,
  input  logic [YW-1:0]           dp_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [YW-1:0]           rsp_y,
  output logic                    busy
`ifdef TOP_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]      issue_cnt
`endif
);

  localparam int IDW = id_width(NREQ);
  localparam int OW  = $clog2(RSP_DEPTH + 1);

  logic [IDW-1:0]    ptr, gnt_id, cand, iss_id, push_id;
  logic              gnt_found, accept, pop, push;
  logic [OW-1:0]     occ;
  tag_t              tag_q [DP_LAT];
  logic              tag_id_unused;
  logic [IDW+YW-1:0] rsp_data;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Credits cover every op from accept to pop, so the FIFO can never overflow.
  assign accept = gnt_found && rst_n && (occ < OW'(RSP_DEPTH));
  assign pop    = rsp_valid && rsp_ready;
  assign busy   = (occ != '0);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (gnt_id == IDW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= IDW'(ptr_reset(NREQ));
      dp_e   <= 1'b0;
      dp_a   <= '0;
      dp_b   <= '0;
      dp_c   <= '0;
      iss_id <= '0;
      occ    <= '0;
    end else begin
      dp_e <= accept;
      if (accept) begin
        ptr    <= gnt_id;
        iss_id <= gnt_id;
        dp_a   <= req_a[gnt_id*W +: W];
        dp_b   <= req_b[gnt_id*W +: W];
        dp_c   <= req_c[gnt_id*W +: W];
      end
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  for (genvar gi = 0; gi < DP_LAT; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_q[gi] <= '0;
      end else if (gi == 0) begin
        tag_q[gi] <= '{valid: dp_e, id: ID_MAXW'(iss_id)};
      end else begin
        tag_q[gi] <= tag_q[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  assign push          = tag_q[DP_LAT-1].valid;
  assign push_id       = IDW'(tag_q[DP_LAT-1].id);
  assign tag_id_unused = ^tag_q[DP_LAT-1].id;

  top_sched_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .DW    (IDW + YW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .din       ({push_id, dp_y}),
    .pop       (pop),
    .out_valid (rsp_valid),
    .dout      (rsp_data)
  );

  assign rsp_id = rsp_data[IDW+YW-1:YW];
  assign rsp_y  = rsp_data[YW-1:0];

`ifdef TOP_SCHED_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        issue_cnt[gi*16 +: 16] <= '0;
      end else if (req_ready[gi] && (issue_cnt[gi*16 +: 16] != 16'hFFFF)) begin
        issue_cnt[gi*16 +: 16] <= issue_cnt[gi*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_top_sched.sv
// tb_top_sched: directed bench for top_sched with a two-stage a+b+c datapath model.
// Exercises TOP_SCHED_STATS_EN counters when that macro is defined.
`timescale 1ns/1ps
module tb_top_sched;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int YW   = 14;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b, req_c;
  logic              dp_e;
  logic [W-1:0]      dp_a, dp_b, dp_c;
  logic [YW-1:0]     dp_y;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [YW-1:0]     rsp_y;
  logic              busy;
`ifdef TOP_SCHED_STATS_EN
  logic [NREQ*16-1:0] issue_cnt;
`endif

  top_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .dp_e      (dp_e),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_c      (dp_c),
    .dp_y      (dp_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
`ifdef TOP_SCHED_STATS_EN
    ,
    .issue_cnt (issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: result valid two edges after the edge that samples dp_e.
  logic [YW-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= YW'(dp_a) + YW'(dp_b) + YW'(dp_c);
    p2 <= p1;
  end
  assign dp_y = p2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            id;
    logic [YW-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   acc_ids[$];
  int   acc_cyc[$];
  int   rsp_cnt = 0;
  int   rsp_seen_valid = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record accepts with the model result, match pops in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i;
          e.y  = YW'(req_a[i*W +: W]) + YW'(req_b[i*W +: W]) + YW'(req_c[i*W +: W]);
          exp_q.push_back(e);
          acc_ids.push_back(i);
          acc_cyc.push_back(cyc);
          $display("accept  id=%0d cyc=%0d exp_y=0x%0h", i, cyc, e.y);
        end
      end
      if (rsp_valid) rsp_seen_valid++;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        $display("respond id=%0d y=0x%0h cyc=%0d", rsp_id, rsp_y, cyc);
        check_eq("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_id_order", 32'(rsp_id), 32'(e.id));
          check_eq("rsp_y_value", 32'(rsp_y), 32'(e.y));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 12'(32'h0A0 + 32'h111 * i);
      req_b[i*W +: W] = 12'(32'h805 - 32'h0F3 * i);
      req_c[i*W +: W] = 12'(32'h033 * (i + 1));
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) tick();
    #2;
    check_eq("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    repeat (2) tick();

    // Reset state, with requests pending.
    req_valid = '1;
    #2;
    check_eq("rst_dp_e", 32'(dp_e), 32'd0);
    check_eq("rst_dp_a", 32'(dp_a), 32'd0);
    check_eq("rst_dp_b", 32'(dp_b), 32'd0);
    check_eq("rst_dp_c", 32'(dp_c), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_y", 32'(rsp_y), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single request from requester 0.
    rsp_ready      = 1'b1;
    req_a[0 +: W]  = 12'hDFC;
    req_b[0 +: W]  = 12'h5B4;
    req_c[0 +: W]  = 12'h0E7;
    req_valid      = 4'b0001;
    #2;
    check_eq("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #2;
    check_eq("single_dp_e", 32'(dp_e), 32'd1);
    check_eq("single_dp_a", 32'(dp_a), 32'hDFC);
    check_eq("single_dp_b", 32'(dp_b), 32'h5B4);
    check_eq("single_dp_c", 32'(dp_c), 32'h0E7);
    check_eq("single_busy", 32'(busy), 32'd1);
    tick();
    #2;
    check_eq("single_dp_e_pulse", 32'(dp_e), 32'd0);
    check_eq("single_rsp_early2", 32'(rsp_valid), 32'd0);
    tick();
    #2;
    check_eq("single_rsp_early3", 32'(rsp_valid), 32'd0);
    tick();
    #2;
    check_eq("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("single_rsp_y", 32'(rsp_y), 32'h1497);
    tick();
    #2;
    check_eq("single_after_pop", 32'(rsp_valid), 32'd0);
    check_eq("single_idle", 32'(busy), 32'd0);

    // Fairness: all requesters active, consumer always ready.
    do_reset();
    load_ops();
    acc_ids.delete();
    acc_cyc.delete();
    rsp_cnt   = 0;
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (12) tick();
    req_valid = '0;
    wait_idle(40);
    check_eq("fair_enough_acc", 32'(acc_ids.size() >= 8), 32'd1);
    for (int k = 0; k < 8; k++) check_eq($sformatf("fair_gnt%0d", k), 32'(acc_ids[k]), 32'(k % NREQ));
    for (int k = 1; k < 4; k++) check_eq($sformatf("fair_b2b%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd1);
    check_eq("fair_rsp_cnt", 32'(rsp_cnt), 32'(acc_ids.size()));

    // Backpressure: consumer stalled, requests continuous.
    do_reset();
    load_ops();
    acc_ids.delete();
    rsp_cnt   = 0;
    req_valid = '1;
    repeat (10) tick();
    #2;
    check_eq("bp_n_acc", 32'(acc_ids.size()), 32'd4);
    check_eq("bp_ready", 32'(req_ready), 32'd0);
    check_eq("bp_busy", 32'(busy), 32'd1);
    check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_head_id", 32'(rsp_id), 32'd0);
    check_eq("bp_head_y", 32'(rsp_y), 32'h8D8);
    repeat (3) tick();
    #2;
    check_eq("bp_hold_id", 32'(rsp_id), 32'd0);
    check_eq("bp_hold_y", 32'(rsp_y), 32'h8D8);
    check_eq("bp_hold_busy", 32'(busy), 32'd1);

    // Full boundary: a lone pop frees one slot; accept+pop keeps occupancy.
    tick();
    rsp_ready = 1'b1;
    #2;
    check_eq("full_pop_cycle", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    #2;
    check_eq("full_after_pop", 32'(req_ready), 32'h1);
    tick();
    rsp_ready = 1'b1;
    #2;
    check_eq("full_again", 32'(req_ready), 32'd0);
    tick();
    #2;
    check_eq("full_acc_and_pop", 32'(req_ready), 32'h2);
    tick();
    rsp_ready = 1'b0;
    #2;
    check_eq("full_occ_kept", 32'(req_ready), 32'h4);
    tick();
    #2;
    check_eq("full_refilled", 32'(req_ready), 32'd0);
    check_eq("full_busy", 32'(busy), 32'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(40);
    check_eq("bp_rsp_cnt", 32'(rsp_cnt), 32'(acc_ids.size()));

    // Reset with operations in flight.
    do_reset();
    load_ops();
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (3) tick();
    #1;
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check_eq("mid_rst_dp_e", 32'(dp_e), 32'd0);
    check_eq("mid_rst_dp_a", 32'(dp_a), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_seen_valid = 0;
    repeat (10) tick();
    check_eq("mid_rst_no_stale", 32'(rsp_seen_valid), 32'd0);
    req_valid = '1;
    #2;
    check_eq("mid_rst_first_win", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    wait_idle(40);

`ifdef TOP_SCHED_STATS_EN
    // Stats: five accepts for requester 2 only.
    do_reset();
    load_ops();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    begin
      int n_acc;
      n_acc = 0;
      for (int i = 0; i < 40 && n_acc < 5; i++) begin
        #2;
        if (req_ready[2]) n_acc++;
        tick();
      end
    end
    req_valid = '0;
    #2;
    check_eq("stats_slot0", 32'(issue_cnt[0 +: 16]), 32'd0);
    check_eq("stats_slot1", 32'(issue_cnt[16 +: 16]), 32'd0);
    check_eq("stats_slot2", 32'(issue_cnt[32 +: 16]), 32'd5);
    check_eq("stats_slot3", 32'(issue_cnt[48 +: 16]), 32'd0);
    wait_idle(40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
